// File: rtl/aud_adc_recorder.sv
// Left-channel I2S receiver for the WM8731 ADC path. It deserialises each left word
// and presents it with an incrementing SRAM word address for the write path.
module aud_adc_recorder #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_AUD_BCLK,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_ADCDAT,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    LEAD   = 3'd2,
    SHIFT  = 3'd3,
    EMIT   = 3'd4,
    PAUSED = 3'd5
  } state_t;

  logic [1:0]        bclk_sync_q, lrc_sync_q, dat_sync_q;
  logic              bclk_hist_q, lrc_hist_q;
  logic              bclk_rise, lrc_fall, dat;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pause_q, pause_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;

  // DAT shares the BCLK synchroniser depth, so it is stable whenever a rise is seen.
  assign bclk_rise = bclk_sync_q[1] & ~bclk_hist_q;
  assign lrc_fall  = ~lrc_sync_q[1] & lrc_hist_q;
  assign dat       = dat_sync_q[1];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    pause_d = pause_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    full_d  = full_q;
    if (i_stop && state_q != IDLE && state_q != EMIT) begin
      state_d = IDLE;
      pause_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = ARM;
            addr_d  = '0;
            full_d  = 1'b0;
          end
        end
        ARM: begin
          if (i_pause || pause_q) begin
            state_d = PAUSED;
            pause_d = 1'b0;
          end else if (lrc_fall) begin
            state_d = LEAD;
          end
        end
        LEAD: begin
          if (i_pause) pause_d = 1'b1;
          if (bclk_rise) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (i_pause) pause_d = 1'b1;
          if (lrc_fall) begin
            state_d = LEAD;
            cnt_d   = '0;
          end else if (bclk_rise) begin
            shreg_d = {shreg_q[DATA_W-2:0], dat};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d = EMIT;
              data_d  = shreg_d;
              valid_d = 1'b1;
              full_d  = (addr_q == MAX_ADDR);
            end
          end
        end
        EMIT: begin
          // The word just emitted counts as written even if a stop arrives now.
          if (full_q) begin
            state_d = IDLE;
            pause_d = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
            if (i_stop) begin
              state_d = IDLE;
              pause_d = 1'b0;
            end else if (pause_q) begin
              state_d = PAUSED;
              pause_d = 1'b0;
            end else begin
              state_d = ARM;
            end
          end
        end
        PAUSED: begin
          if (i_start) state_d = ARM;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      dat_sync_q  <= '0;
      bclk_hist_q <= 1'b0;
      lrc_hist_q  <= 1'b0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      pause_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], i_AUD_BCLK};
      lrc_sync_q  <= {lrc_sync_q[0], i_AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[0], i_AUD_ADCDAT};
      bclk_hist_q <= bclk_sync_q[1];
      lrc_hist_q  <= lrc_sync_q[1];
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      pause_q     <= pause_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      full_q      <= full_d;
    end
  end

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_full    = full_q;
  assign o_busy    = (state_q == ARM) || (state_q == LEAD) ||
                     (state_q == SHIFT) || (state_q == EMIT);

endmodule
